laser_pack_fifo: RTL and testbench

Parametrised byte FIFO for the LaserDrop datapath that accepts `IN_BYTES`-wide words from the host side and drains them one byte at a time toward the laser serialiser. It handles simultaneous load and drain, wrap-around writes that straddle the end of storage, and byte-accurate occupancy. It adds a ready/valid handshake so neither side can overrun or underrun it.

---
 rtl/laser_pack_fifo_pkg.sv | 15 +
 rtl/laser_pack_fifo_if.sv | 44 ++++
 rtl/laser_pack_fifo_byte_ram.sv | 41 ++++
 rtl/laser_pack_fifo.sv | 111 +++++++++++
 tb/tb_laser_pack_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/laser_pack_fifo_pkg.sv
// -----------------------------------------------------------------------------
// laser_fifo_pkg
// Shared types and helpers for the LaserDrop byte packing FIFO.
//   byte_t       : one storage byte
//   count_width  : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package laser_fifo_pkg;

    typedef logic [7:0] byte_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/laser_pack_fifo_if.sv
// -----------------------------------------------------------------------------
// laser_pack_fifo_if
// Host/serialiser handshake bundle for laser_pack_fifo.
//   wr_data, wr_en, wr_ready : multi-byte write side
//   rd_en, rd_valid, rd_data : show-ahead byte read side
//   count                    : occupancy in bytes
//   overflow, underflow      : sticky error flags (LASER_PACK_FIFO_ERR_EN only)
// Modports: master = traffic source/sink (host + serialiser), slave = FIFO.
// -----------------------------------------------------------------------------
interface laser_pack_fifo_if
    import laser_fifo_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int IN_BYTES = 2
);
    logic [8*IN_BYTES-1:0]        wr_data;
    logic                         wr_en;
    logic                         wr_ready;
    logic                         rd_en;
    logic                         rd_valid;
    byte_t                        rd_data;
    logic [count_width(DEPTH)-1:0] count;
`ifdef LASER_PACK_FIFO_ERR_EN
    logic                         overflow;
    logic                         underflow;
`endif

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_ready, rd_valid, rd_data, count
`ifdef LASER_PACK_FIFO_ERR_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_ready, rd_valid, rd_data, count
`ifdef LASER_PACK_FIFO_ERR_EN
        , output overflow, underflow
`endif
    );

endinterface

// File: rtl/laser_pack_fifo_byte_ram.sv
// -----------------------------------------------------------------------------
// laser_byte_ram
// DEPTH x 8 storage with one IN_BYTES-lane write port and one asynchronous
// byte read port. Write lane i lands at (wr_addr_i + i) mod DEPTH, so a word
// may straddle the end of storage. Contents are never reset.
//   clock      : rising-edge clock
//   wr_en_i    : write all lanes this edge
//   wr_addr_i  : address of lane 0
//   wr_data_i  : lane i is wr_data_i[8*i +: 8]
//   rd_addr_i  : read address
//   rd_data_o  : byte at rd_addr_i (combinational)
// -----------------------------------------------------------------------------
module laser_byte_ram
    import laser_fifo_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int IN_BYTES = 2
) (
    input  logic                       clock,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [8*IN_BYTES-1:0]      wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output byte_t                      rd_data_o
);
    localparam int AW = $clog2(DEPTH);

    byte_t mem_q [DEPTH];

    // Address arithmetic is AW bits wide, so the lane offset wraps mod DEPTH.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                mem_q[wr_addr_i + AW'(i)] <= wr_data_i[8*i +: 8];
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/laser_pack_fifo.sv
// -----------------------------------------------------------------------------
// laser_pack_fifo
// Byte FIFO: accepts IN_BYTES-wide words, drains one byte per pop, with
// byte-accurate occupancy and ready/valid handshakes on both sides.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high; clears pointers, count and flags
//   clear   : synchronous flush, priority over wr_en/rd_en
//   fifo_if : laser_pack_fifo_if.slave (write, read, count, flags)
// Optional feature macro: LASER_PACK_FIFO_ERR_EN adds sticky overflow and
// underflow flags; without it dropped requests are silent.
// -----------------------------------------------------------------------------
module laser_pack_fifo
    import laser_fifo_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int IN_BYTES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    laser_pack_fifo_if.slave fifo_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_ready;
    logic          rd_valid;
    logic          wr_fire;
    logic          rd_fire;
    byte_t         head;

    // Status depends on registered count only; a same-cycle pop never makes
    // room for a write, and a same-cycle write never makes a pop valid.
    assign wr_ready = (count_q <= CW'(DEPTH - IN_BYTES));
    assign rd_valid = (count_q != '0);
    assign wr_fire  = fifo_if.wr_en && wr_ready;
    assign rd_fire  = fifo_if.rd_en && rd_valid;

    laser_byte_ram #(
        .DEPTH    (DEPTH),
        .IN_BYTES (IN_BYTES)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_fire && !clear),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_if.wr_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(IN_BYTES);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q
                + (wr_fire ? CW'(IN_BYTES) : CW'(0))
                - (rd_fire ? CW'(1)        : CW'(0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fifo_if.wr_ready = wr_ready;
    assign fifo_if.rd_valid = rd_valid;
    assign fifo_if.rd_data  = rd_valid ? head : 8'h00;
    assign fifo_if.count    = count_q;

`ifdef LASER_PACK_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (fifo_if.wr_en && !wr_ready);
        underflow_d = underflow_q | (fifo_if.rd_en && !rd_valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_if.overflow  = overflow_q;
    assign fifo_if.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_laser_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_laser_pack_fifo
// Bench for laser_pack_fifo. A byte-queue model tracks the FIFO contents and
// flags; a negedge process compares every DUT output against it each cycle.
// Directed scenarios add literal expectations, then a randomized phase runs.
// A second instance with IN_BYTES=3 exercises a word straddling the wrap.
// -----------------------------------------------------------------------------
module tb_laser_pack_fifo;
    import laser_fifo_pkg::*;

    localparam int DEPTH = 64;
    localparam int INB   = 2;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic clear  = 1'b0;
    logic clear2 = 1'b0;

    always #5 clock = ~clock;

    laser_pack_fifo_if #(.DEPTH(DEPTH), .IN_BYTES(INB)) b1 ();
    laser_pack_fifo_if #(.DEPTH(DEPTH), .IN_BYTES(3))   b2 ();

    laser_pack_fifo #(.DEPTH(DEPTH), .IN_BYTES(INB)) dut (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .fifo_if (b1)
    );

    laser_pack_fifo #(.DEPTH(DEPTH), .IN_BYTES(3)) dut3 (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear2),
        .fifo_if (b2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: FIFO as a byte queue ----------------
    byte_t mq[$];
    logic  m_ovf = 1'b0;
    logic  m_unf = 1'b0;
    logic  m_wok;
    logic  m_rok;

    always @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_wok = (mq.size() <= DEPTH - INB);
            m_rok = (mq.size() != 0);
            if (b1.wr_en && !m_wok) m_ovf = 1'b1;
            if (b1.rd_en && !m_rok) m_unf = 1'b1;
            if (b1.rd_en && m_rok) void'(mq.pop_front());
            if (b1.wr_en && m_wok)
                for (int i = 0; i < INB; i++) mq.push_back(b1.wr_data[8*i +: 8]);
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clock) begin
        chk("count",    32'(b1.count),    32'(mq.size()));
        chk("rd_valid", 32'(b1.rd_valid), 32'(mq.size() != 0));
        chk("wr_ready", 32'(b1.wr_ready), 32'(mq.size() <= DEPTH - INB));
        chk("rd_data",  32'(b1.rd_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
`ifdef LASER_PACK_FIFO_ERR_EN
        chk("overflow",  32'(b1.overflow),  32'(m_ovf));
        chk("underflow", 32'(b1.underflow), 32'(m_unf));
`endif
    end

    // ---------------- drivers ----------------
    task automatic cyc(input logic we, input logic [15:0] d, input logic re, input logic cl);
        b1.wr_en   = we;
        b1.wr_data = d;
        b1.rd_en   = re;
        clear      = cl;
        @(posedge clock);
        #1;
        b1.wr_en = 1'b0;
        b1.rd_en = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic cyc2(input logic we, input logic [23:0] d, input logic re);
        b2.wr_en   = we;
        b2.wr_data = d;
        b2.rd_en   = re;
        @(posedge clock);
        #1;
        b2.wr_en = 1'b0;
        b2.rd_en = 1'b0;
    endtask

    initial begin
        b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.wr_data = '0;
        b2.wr_en = 1'b0; b2.rd_en = 1'b0; b2.wr_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset values
        chk("rst_count",    32'(b1.count),    32'd0);
        chk("rst_rd_valid", 32'(b1.rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(b1.wr_ready), 32'd1);
        chk("rst_rd_data",  32'(b1.rd_data),  32'h00);

        // Single word then two pops
        cyc(1'b1, 16'hBBAA, 1'b0, 1'b0);
        chk("w1_head",  32'(b1.rd_data), 32'hAA);
        chk("w1_count", 32'(b1.count),   32'd2);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("p1_head",  32'(b1.rd_data), 32'hBB);
        chk("p1_count", 32'(b1.count),   32'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("p2_count", 32'(b1.count),   32'd0);
        chk("p2_head",  32'(b1.rd_data), 32'h00);

        // Fill to DEPTH, then one dropped write
        for (int k = 0; k < 32; k++) cyc(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
        chk("full_count",    32'(b1.count),    32'd64);
        chk("full_wr_ready", 32'(b1.wr_ready), 32'd0);
        cyc(1'b1, 16'hEEEE, 1'b0, 1'b0);
        chk("drop_count", 32'(b1.count), 32'd64);
`ifdef LASER_PACK_FIFO_ERR_EN
        chk("drop_overflow", 32'(b1.overflow), 32'd1);
`endif

        // 63 stored: a same-cycle pop does not open room for the write
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("c63_count",    32'(b1.count),    32'd63);
        chk("c63_wr_ready", 32'(b1.wr_ready), 32'd0);
        chk("c63_head",     32'(b1.rd_data),  32'h01);
        cyc(1'b1, 16'h7777, 1'b1, 1'b0);
        chk("wr_rd_count", 32'(b1.count), 32'd62);
        cyc(1'b1, 16'h7878, 1'b0, 1'b0);
        chk("refill_count", 32'(b1.count), 32'd64);

        // Flush
        cyc(1'b1, 16'h5555, 1'b1, 1'b1);
        chk("clr_count",    32'(b1.count),    32'd0);
        chk("clr_rd_valid", 32'(b1.rd_valid), 32'd0);
        chk("clr_wr_ready", 32'(b1.wr_ready), 32'd1);
`ifdef LASER_PACK_FIFO_ERR_EN
        chk("clr_overflow", 32'(b1.overflow), 32'd0);
`endif

        // Write into empty with a same-cycle pop: pop ignored, no bypass
        cyc(1'b1, 16'h2211, 1'b1, 1'b0);
        chk("nobyp_count", 32'(b1.count),   32'd2);
        chk("nobyp_head",  32'(b1.rd_data), 32'h11);
`ifdef LASER_PACK_FIFO_ERR_EN
        chk("nobyp_underflow", 32'(b1.underflow), 32'd1);
`endif
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Sustained write+read each cycle, clear mid-stream
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 16'($urandom), 1'b1, (i == 60));
            if (i == 0)  chk("strm_count0",  32'(b1.count), 32'd2);
            if (i == 10) chk("strm_count10", 32'(b1.count), 32'd12);
            if (i == 59) chk("strm_count59", 32'(b1.count), 32'd61);
            if (i == 60) chk("strm_clear",   32'(b1.count), 32'd0);
            if (i == 61) chk("strm_count61", 32'(b1.count), 32'd2);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("areset_count",    32'(b1.count),    32'd0);
        chk("areset_rd_valid", 32'(b1.rd_valid), 32'd0);
        chk("areset_rd_data",  32'(b1.rd_data),  32'h00);
        @(posedge clock);
        #1 reset = 1'b0;

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 800; i++) begin
            automatic bit fillp = ((i / 100) % 2) == 0;
            automatic logic we  = $urandom_range(0, 99) < (fillp ? 85 : 30);
            automatic logic re  = $urandom_range(0, 99) < (fillp ? 30 : 85);
            automatic logic cl  = $urandom_range(0, 199) == 0;
            cyc(we, 16'($urandom), re, cl);
        end

        // IN_BYTES=3 instance: walk wr_ptr to 63, then write a straddling word
        for (int k = 0; k < 21; k++) begin
            cyc2(1'b1, 24'($urandom), 1'b0);
            repeat (3) cyc2(1'b0, 24'h0, 1'b1);
        end
        chk("w3_empty", 32'(b2.count), 32'd0);
        cyc2(1'b1, 24'hD3D2D1, 1'b0);
        chk("wrap_count", 32'(b2.count),   32'd3);
        chk("wrap_b0",    32'(b2.rd_data), 32'hD1);
        cyc2(1'b0, 24'h0, 1'b1);
        chk("wrap_b1",    32'(b2.rd_data), 32'hD2);
        cyc2(1'b0, 24'h0, 1'b1);
        chk("wrap_b2",    32'(b2.rd_data), 32'hD3);
        cyc2(1'b0, 24'h0, 1'b1);
        chk("wrap_done",  32'(b2.count),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
